// File: rtl/riscv_wrapper_shell_pkg.sv
// ----------------------------------------------------------------------------
// riscv_wrapper_pkg
// Shared constants, LBIST state encoding and the LFSR/MISR step function for
// the RI5CY wrapper shell.
//   LFSR_POLY    : feedback taps of x^32+x^22+x^2+x+1 (bit 32 implied)
//   MIX_CONST    : additive constant used to scramble LFSR patterns
//   STATUS_ADDR  : test status register (pass / fail magic values)
//   EXIT_ADDR    : exit code register
//   DRAM_LO/HI   : legal data-memory window for the optional range check
// ----------------------------------------------------------------------------
package riscv_wrapper_pkg;

    localparam logic [31:0] LFSR_POLY   = 32'h0040_0007;
    localparam logic [31:0] MIX_CONST   = 32'h9E37_79B9;
    localparam logic [31:0] STATUS_ADDR = 32'h2000_0000;
    localparam logic [31:0] EXIT_ADDR   = 32'h2000_0004;
    localparam logic [31:0] PASS_MAGIC  = 32'd123456789;
    localparam logic [31:0] FAIL_MAGIC  = 32'd1;
    localparam logic [31:0] DRAM_LO     = 32'h0020_0000;
    localparam logic [31:0] DRAM_HI     = 32'h0024_0000;

    typedef enum logic [1:0] {
        LBIST_IDLE = 2'd0,
        LBIST_RUN  = 2'd1,
        LBIST_DONE = 2'd2
    } lbist_state_e;

    // One Galois shift of the LFSR/MISR polynomial.
    function automatic logic [31:0] step(input logic [31:0] x);
        return {x[30:0], 1'b0} ^ (x[31] ? LFSR_POLY : 32'h0);
    endfunction

    // Pattern scrambler applied to each LFSR value before MISR compaction.
    function automatic logic [31:0] mix(input logic [31:0] x);
        return {x[24:0], x[31:25]} ^ (x + MIX_CONST);
    endfunction

endpackage

// File: rtl/riscv_wrapper_shell_if.sv
// ----------------------------------------------------------------------------
// riscv_wrapper_shell_if
// Core data bus as seen by the wrapper shell.
//   data_req_i   : core data request
//   data_we_i    : write enable
//   data_addr_i  : byte address
//   data_wdata_i : write data
// master drives the bus (core / bench), slave observes it (wrapper shell).
// ----------------------------------------------------------------------------
interface riscv_wrapper_shell_if;

    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;

    modport master (
        output data_req_i,
        output data_we_i,
        output data_addr_i,
        output data_wdata_i
    );

    modport slave (
        input data_req_i,
        input data_we_i,
        input data_addr_i,
        input data_wdata_i
    );

endinterface

// File: rtl/riscv_wrapper_shell_lbist_ctrl.sv
// ----------------------------------------------------------------------------
// lbist_ctrl
// Logic-BIST sequencer: LFSR pattern generator, MISR compactor, pattern
// counter and signature compare.
//   clk_i, rst_i : clock, synchronous active-high reset
//   start_i      : session request level, sampled in IDLE and DONE only
//   go_nogo_o    : 1 = last signature matched GOLDEN_SIG; held until next run
//   busy_o       : session in progress (RUN or DONE)
// ----------------------------------------------------------------------------
module lbist_ctrl
    import riscv_wrapper_pkg::*;
#(
    parameter int          NUM_PATTERNS = 256,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG   = 32'h0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic go_nogo_o,
    output logic busy_o
);

    if (NUM_PATTERNS < 1) begin : g_bad_patterns
        $fatal(1, "lbist_ctrl: NUM_PATTERNS must be >= 1");
    end
    if (LFSR_SEED == 32'h0) begin : g_bad_seed
        $fatal(1, "lbist_ctrl: LFSR_SEED must be nonzero");
    end

    localparam logic [31:0] LAST_CNT = 32'(NUM_PATTERNS - 1);

    lbist_state_e state_q, state_d;
    logic [31:0]  lfsr_q, lfsr_d;
    logic [31:0]  misr_q, misr_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         go_q, go_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= LBIST_IDLE;
            lfsr_q  <= '0;
            misr_q  <= '0;
            cnt_q   <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            cnt_q   <= cnt_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        // NOTE: every next-state value gets its hold default first so no
        // path through the case statement can infer a latch.
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        cnt_d   = cnt_q;
        go_d    = go_q;

        unique case (state_q)
            LBIST_IDLE, LBIST_DONE: begin
                if (start_i) begin
                    state_d = LBIST_RUN;
                    lfsr_d  = LFSR_SEED;
                    misr_d  = '0;
                    cnt_d   = '0;
                    go_d    = 1'b0;
                end else begin
                    state_d = LBIST_IDLE;
                end
            end
            LBIST_RUN: begin
                misr_d = step(misr_q) ^ mix(lfsr_q);
                lfsr_d = step(lfsr_q);
                cnt_d  = cnt_q + 32'd1;
                // Compare the final signature on the way into DONE so the
                // verdict is visible during DONE even when a back-to-back
                // session clears it on the following edge.
                if (cnt_q == LAST_CNT) begin
                    state_d = LBIST_DONE;
                    go_d    = (misr_d == GOLDEN_SIG);
                end
            end
            default: state_d = LBIST_IDLE;
        endcase
    end

    assign go_nogo_o = go_q;
    assign busy_o    = (state_q != LBIST_IDLE);

endmodule

// File: rtl/riscv_wrapper_shell.sv
// ----------------------------------------------------------------------------
// riscv_wrapper_shell
// System shell around the RI5CY core. Runs an LBIST session while holding the
// core in reset, then decodes core data-bus writes into the status peripheral.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   start, go_nogo      : LBIST request level / result (1 = pass)
//   lbist_busy_o        : session in progress
//   fetch_enable_i      : fetch enable request from the bench
//   core_fetch_enable_o : fetch enable to core, blocked during LBIST
//   core_rst_o          : core reset, asserted during reset and LBIST
//   boot_addr_o         : BOOT_ADDR
//   dbus                : core data bus (slave view)
//   tests_passed_o/tests_failed_o/exit_valid_o : 1-cycle status pulses
//   exit_value_o        : last exit code written
// Optional: define MM_CHECK_EN to add mm_warn_o, a 1-cycle pulse after any
// write outside the DRAM window.
// ----------------------------------------------------------------------------
module riscv_wrapper_shell
    import riscv_wrapper_pkg::*;
#(
    parameter int          INSTR_RDATA_WIDTH = 128,
    parameter int          RAM_ADDR_WIDTH    = 22,
    parameter logic [31:0] BOOT_ADDR         = 32'h80,
    parameter int          NUM_PATTERNS      = 256,
    parameter logic [31:0] LFSR_SEED         = 32'hACE1_2468,
    parameter logic [31:0] GOLDEN_SIG        = 32'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start,
    output logic                  go_nogo,
    output logic                  lbist_busy_o,
    input  logic                  fetch_enable_i,
    output logic                  core_fetch_enable_o,
    output logic                  core_rst_o,
    output logic [31:0]           boot_addr_o,
    riscv_wrapper_shell_if.slave  dbus,
    output logic                  tests_passed_o,
    output logic                  tests_failed_o,
    output logic                  exit_valid_o,
    output logic [31:0]           exit_value_o
`ifdef MM_CHECK_EN
    ,
    output logic                  mm_warn_o
`endif
);

    if (INSTR_RDATA_WIDTH != 32 && INSTR_RDATA_WIDTH != 128) begin : g_bad_width
        $fatal(1, "riscv_wrapper_shell: INSTR_RDATA_WIDTH must be 32 or 128");
    end
    // RAM_ADDR_WIDTH is only forwarded to the RAM instance.
    if (RAM_ADDR_WIDTH < 1) begin : g_bad_ram
        $fatal(1, "riscv_wrapper_shell: RAM_ADDR_WIDTH must be >= 1");
    end

    lbist_ctrl #(
        .NUM_PATTERNS (NUM_PATTERNS),
        .LFSR_SEED    (LFSR_SEED),
        .GOLDEN_SIG   (GOLDEN_SIG)
    ) u_lbist_ctrl (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start),
        .go_nogo_o (go_nogo),
        .busy_o    (lbist_busy_o)
    );

    assign core_fetch_enable_o = fetch_enable_i & ~lbist_busy_o;
    assign core_rst_o          = rst_i | lbist_busy_o;
    assign boot_addr_o         = BOOT_ADDR;

    // The core is in reset during LBIST, so any bus activity then is noise.
    logic wr;
    assign wr = dbus.data_req_i & dbus.data_we_i & ~lbist_busy_o;

    logic        passed_q, failed_q, exit_valid_q;
    logic [31:0] exit_value_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            passed_q     <= 1'b0;
            failed_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= '0;
        end else begin
            passed_q     <= wr && dbus.data_addr_i == STATUS_ADDR
                               && dbus.data_wdata_i == PASS_MAGIC;
            failed_q     <= wr && dbus.data_addr_i == STATUS_ADDR
                               && dbus.data_wdata_i == FAIL_MAGIC;
            exit_valid_q <= wr && dbus.data_addr_i == EXIT_ADDR;
            if (wr && dbus.data_addr_i == EXIT_ADDR) begin
                exit_value_q <= dbus.data_wdata_i;
            end
        end
    end

    assign tests_passed_o = passed_q;
    assign tests_failed_o = failed_q;
    assign exit_valid_o   = exit_valid_q;
    assign exit_value_o   = exit_value_q;

`ifdef MM_CHECK_EN
    logic out_of_range;
    logic mm_warn_q;
    assign out_of_range = wr && (dbus.data_addr_i < DRAM_LO || dbus.data_addr_i > DRAM_HI);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mm_warn_q <= 1'b0;
        end else begin
            mm_warn_q <= out_of_range;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i && out_of_range) begin
            $display("WARNING: data write outside DRAM at addr %h, time %0t",
                     dbus.data_addr_i, $time);
        end
    end
`endif

    assign mm_warn_o = mm_warn_q;
`endif

endmodule

// File: tb/tb_riscv_wrapper_shell.sv
// ----------------------------------------------------------------------------
// tb_riscv_wrapper_shell
// Directed bench for riscv_wrapper_shell. Two instances share all inputs:
// u_dut carries the model signature as GOLDEN_SIG, u_bad carries it with
// bit 0 flipped and must never report a pass.
// ----------------------------------------------------------------------------
module tb_riscv_wrapper_shell;

    localparam int          NPAT = 256;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    function automatic logic [31:0] m_step(input logic [31:0] x);
        logic [31:0] y;
        y = x << 1;
        if (x[31]) y = y ^ 32'h0040_0007;
        return y;
    endfunction

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] l, m, r;
        l = SEED;
        m = 32'h0;
        for (int i = 0; i < n; i++) begin
            r = ((l << 7) | (l >> 25)) ^ (l + 32'h9E37_79B9);
            m = m_step(m) ^ r;
            l = m_step(l);
        end
        return m;
    endfunction

    localparam logic [31:0] SIG = model_sig(NPAT);

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start;
    logic        fetch_enable_i;

    logic        go_nogo, busy, core_fe, core_rst, passed, failed, exit_valid;
    logic [31:0] boot_addr, exit_value;
    logic        go_nogo_b, busy_b, core_fe_b, core_rst_b, passed_b, failed_b, exit_valid_b;
    logic [31:0] boot_addr_b, exit_value_b;
`ifdef MM_CHECK_EN
    logic        mm_warn, mm_warn_b;
`endif

    riscv_wrapper_shell_if bus_if ();

    always #5 clk_i = ~clk_i;

    riscv_wrapper_shell #(
        .NUM_PATTERNS (NPAT),
        .LFSR_SEED    (SEED),
        .GOLDEN_SIG   (SIG)
    ) u_dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start               (start),
        .go_nogo             (go_nogo),
        .lbist_busy_o        (busy),
        .fetch_enable_i      (fetch_enable_i),
        .core_fetch_enable_o (core_fe),
        .core_rst_o          (core_rst),
        .boot_addr_o         (boot_addr),
        .dbus                (bus_if.slave),
        .tests_passed_o      (passed),
        .tests_failed_o      (failed),
        .exit_valid_o        (exit_valid),
        .exit_value_o        (exit_value)
`ifdef MM_CHECK_EN
        ,
        .mm_warn_o           (mm_warn)
`endif
    );

    riscv_wrapper_shell #(
        .NUM_PATTERNS (NPAT),
        .LFSR_SEED    (SEED),
        .GOLDEN_SIG   (SIG ^ 32'h1)
    ) u_bad (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .start               (start),
        .go_nogo             (go_nogo_b),
        .lbist_busy_o        (busy_b),
        .fetch_enable_i      (fetch_enable_i),
        .core_fetch_enable_o (core_fe_b),
        .core_rst_o          (core_rst_b),
        .boot_addr_o         (boot_addr_b),
        .dbus                (bus_if.slave),
        .tests_passed_o      (passed_b),
        .tests_failed_o      (failed_b),
        .exit_valid_o        (exit_valid_b),
        .exit_value_o        (exit_value_b)
`ifdef MM_CHECK_EN
        ,
        .mm_warn_o           (mm_warn_b)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.data_req_i   = 1'b1;
        bus_if.data_we_i    = 1'b1;
        bus_if.data_addr_i  = addr;
        bus_if.data_wdata_i = data;
    endtask

    task automatic bus_idle();
        bus_if.data_req_i   = 1'b0;
        bus_if.data_we_i    = 1'b0;
        bus_if.data_addr_i  = 32'h0;
        bus_if.data_wdata_i = 32'h0;
    endtask

    initial begin
        int bad;
        int cyc;
        int guard;

        rst_i = 1'b1;
        start = 1'b0;
        fetch_enable_i = 1'b1;
        bus_idle();
        tick(2);

        // Reset state
        check("rst_go_nogo", {31'h0, go_nogo}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_core_rst", {31'h0, core_rst}, 32'h1);
        check("rst_pulses", {29'h0, passed, failed, exit_valid}, 32'h0);
        check("rst_exit_value", exit_value, 32'h0);
        check("boot_addr", boot_addr, 32'h80);

        rst_i = 1'b0;
        tick();
        check("idle_core_rst", {31'h0, core_rst}, 32'h0);
        check("idle_fetch_en", {31'h0, core_fe}, 32'h1);

        // First session, start held through DONE
        start = 1'b1;
        tick();
        check("run_busy", {31'h0, busy}, 32'h1);
        check("run_core_rst", {31'h0, core_rst}, 32'h1);
        check("run_fetch_blocked", {31'h0, core_fe}, 32'h0);
        bad = 0;
        for (int i = 1; i < NPAT; i++) begin
            tick();
            if (busy !== 1'b1 || go_nogo !== 1'b0) bad++;
        end
        check("run1_busy_no_verdict", bad, 0);
        tick();
        check("done1_busy", {31'h0, busy}, 32'h1);
        check("done1_go_nogo", {31'h0, go_nogo}, 32'h1);
        check("done1_bad_go_nogo", {31'h0, go_nogo_b}, 32'h0);

        // Back-to-back second session, start dropped after re-entry
        tick();
        start = 1'b0;
        check("rerun_go_nogo_cleared", {31'h0, go_nogo}, 32'h0);
        check("rerun_busy", {31'h0, busy}, 32'h1);
        tick(NPAT - 1);
        check("run2_last_busy", {30'h0, busy, go_nogo}, 32'h2);
        tick();
        check("done2_go_nogo", {30'h0, busy, go_nogo}, 32'h3);
        tick();
        check("idle2_busy", {31'h0, busy}, 32'h0);
        check("idle2_go_nogo_held", {31'h0, go_nogo}, 32'h1);
        check("idle2_bad_go_nogo", {31'h0, go_nogo_b}, 32'h0);
        check("idle2_core_rst", {31'h0, core_rst}, 32'h0);

        // Status peripheral: pass then fail back-to-back
        bus_write(32'h2000_0000, 32'd123456789);
        tick();
        check("pass_pulse", {30'h0, passed, failed}, 32'h2);
        bus_write(32'h2000_0000, 32'd1);
        tick();
        check("fail_pulse", {30'h0, passed, failed}, 32'h1);
        bus_write(32'h2000_0000, 32'hDEAD);
        tick();
        check("status_other_ignored", {30'h0, passed, failed}, 32'h0);

        // Exit code
        bus_write(32'h2000_0004, 32'h2A);
        tick();
        check("exit_pulse", {31'h0, exit_valid}, 32'h1);
        check("exit_value", exit_value, 32'd42);
        bus_if.data_we_i    = 1'b0;
        bus_if.data_wdata_i = 32'h7;
        tick();
        check("exit_read_ignored", {31'h0, exit_valid}, 32'h0);
        check("exit_value_held", exit_value, 32'd42);
        bus_idle();

        // Writes during LBIST are ignored; dropping start mid-RUN completes the run
        start = 1'b1;
        tick();
        cyc = busy ? 1 : 0;
        start = 1'b0;
        bus_write(32'h2000_0004, 32'd99);
        tick();
        if (busy) cyc++;
        check("lbist_exit_blocked", {31'h0, exit_valid}, 32'h0);
        check("lbist_exit_value_kept", exit_value, 32'd42);
        bus_write(32'h2000_0000, 32'd123456789);
        tick();
        if (busy) cyc++;
        check("lbist_pass_blocked", {31'h0, passed}, 32'h0);
        bus_idle();
        guard = 0;
        while (busy && guard < 1000) begin
            tick();
            guard++;
            if (busy) cyc++;
        end
        check("session_busy_cycles", cyc, 257);
        check("session3_go_nogo", {31'h0, go_nogo}, 32'h1);

        // Reset mid-session aborts without a verdict
        start = 1'b1;
        tick(6);
        check("abort_pre_busy", {31'h0, busy}, 32'h1);
        rst_i = 1'b1;
        start = 1'b0;
        tick();
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_go_nogo", {31'h0, go_nogo}, 32'h0);
        rst_i = 1'b0;
        tick();
        check("abort_idle", {31'h0, busy}, 32'h0);

`ifdef MM_CHECK_EN
        bus_write(32'h0030_0000, 32'h1);
        tick();
        check("mm_warn_out", {31'h0, mm_warn}, 32'h1);
        bus_write(32'h0021_0000, 32'h1);
        tick();
        check("mm_warn_in", {31'h0, mm_warn}, 32'h0);
        bus_idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
